add8_mp_seq: RTL
================

Name: add8_mp_seq

Overview:
Sequencer that time-multiplexes one shared combinational 8-bit adder (a, b, cin -> sum, cout) to perform WORDS-byte multi-precision add or subtract.
- Operands are captured on a start pulse and processed one byte per clock, LSB byte first, with the carry chained through a register.
- Sits between a requesting datapath and the add8 instance; it drives the adder inputs and samples its outputs.
- Reports the result with a one-cycle done pulse plus carry and signed-overflow flags.

Parameters:
WORDS, 4, number of 8-bit bytes per operand (>=1); operand width W = 8*WORDS.
IDXW, $clog2(WORDS) (min 1), width of the internal byte index.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
sub  input  1  0 = opa+opb+cin_in; 1 = opa-opb (cin_in ignored).
cin_in  input  1  carry-in for add mode.
opa  input  W  operand A, captured on accepted start.
opb  input  W  operand B, captured on accepted start.
add_a  output  8  to shared adder input a.
add_b  output  8  to shared adder input b.
add_cin  output  1  to shared adder cin.
add_sum  input  8  from shared adder sum (combinational, same cycle).
add_cout  input  1  from shared adder cout.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse: result valid.
result  output  W  final sum/difference, held until next accepted start.
cout  output  1  final carry out; in sub mode 1 = no borrow.
ovf  output  1  signed two's-complement overflow of the W-bit result.

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, cout, ovf = 0. result = 0. add_a, add_b, add_cin = 0. Index = 0, carry register = 0. An in-flight operation is abandoned and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge captures opa, opb and sub.
  - The same edge sets carry = sub ? 1 : cin_in, idx = 0, clears result, cout and ovf, and moves to RUN.
  - busy goes high on the same edge.
- RUN, combinational adder drive:
  - add_a = A[8*idx +: 8]
  - add_b = B[8*idx +: 8] ^ {8{sub_q}}
  - add_cin = carry
- RUN, each edge:
  - result[8*idx +: 8] <= add_sum; carry <= add_cout; idx <= idx+1.
  - On the edge where idx == WORDS-1: cout <= add_cout; ovf <= (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]); move to DONE.
- DONE: done=1 for exactly this one cycle, busy=1. The next edge returns to IDLE, clears busy and done, and zeroes add_a, add_b, add_cin.
- Latency:
  - Start accepted at edge E0. RUN occupies cycles E0..E0+WORDS. DONE is the cycle after edge E0+WORDS.
  - done is high between edges E0+WORDS and E0+WORDS+1.
  - Throughput: one operation per WORDS+2 cycles. A start is accepted at the earliest on the edge after DONE exits to IDLE.
- start while busy (RUN or DONE): ignored, no queuing. Captured operands and mode are unaffected.
- Operand inputs are sampled only at the accepting edge. Changes afterwards have no effect.
- Outside RUN, the adder inputs are 0. add_sum and add_cout are not sampled.
- WORDS=1: one RUN cycle, then DONE.
- Width rules: all byte arithmetic is in the external adder. Carry is exactly 1 bit. result wraps modulo 2^W.

Test Plan:
- WORDS=4, sub=0, cin_in=0, opa=0x000000FF, opb=0x00000001, start at edge 0 -> result=0x00000100, cout=0, ovf=0. done high only between edges 4 and 5. busy high between edges 0 and 5.
- sub=0, cin_in=1, opa=0xFFFFFFFF, opb=0x00000000 -> result=0x00000000, cout=1, ovf=0. add_cin observed 1 in all four RUN cycles.
- sub=1, opa=0x00000005, opb=0x00000007 -> result=0xFFFFFFFE, cout=0 (borrow), ovf=0. A second run with opa=7, opb=5 -> result=0x00000002, cout=1.
- sub=0, opa=0x7FFFFFFF, opb=0x00000001 -> result=0x80000000, ovf=1, cout=0. sub=1, opa=0x80000000, opb=1 -> result=0x7FFFFFFF, ovf=1.
- Start held high continuously with operands changed mid-RUN -> first result is unaffected. Operations are accepted at edges 0, 6, 12 and exactly one done is produced per operation.
- rst asserted asynchronously during RUN, after 2 bytes -> busy, done, result, cout and ovf are 0 immediately. No done appears. A fresh start after reset release gives the correct result.

Source files
------------

// File: rtl/add8_mp_seq.sv
// add8_mp_seq: drives one shared 8-bit adder for WORDS-byte add/sub.
// Ports:
//   clk/rst                - clock and async active-high reset
//   start/sub/cin_in       - request, mode and carry-in
//   opa/opb                - W-bit operands
//   add_a/add_b/add_cin    - shared adder inputs
//   add_sum/add_cout       - shared adder outputs
//   busy/done              - status: in progress / one-cycle done
//   result/cout/ovf        - W-bit result, carry-out and signed overflow
module add8_mp_seq #(
  parameter int WORDS = 4,
  parameter int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin_in,
  input  logic [8*WORDS-1:0]   opa,
  input  logic [8*WORDS-1:0]   opb,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  input  logic [7:0]           add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W = 8 * WORDS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  logic [1:0]      r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_result;
  logic            r_cout;
  logic            r_ovf;

  logic            w_run;
  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic            w_ovf;

  assign w_run = (r_state == S_RUN);

  // Byte select by index; a loop keeps every slice in range
  // even when WORDS is not a power of two.
  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_byte = r_a[8*i +: 8];
        w_b_byte = r_b[8*i +: 8];
      end
    end
  end

  // Subtraction is A + ~B + 1; the +1 comes from the seeded carry.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (w_run) begin
      add_a   = w_a_byte;
      add_b   = w_b_byte ^ {8{r_sub}};
      add_cin = r_carry;
    end
  end

  // Signed overflow of the top byte: equal input signs, differing sum sign.
  assign w_ovf = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= opa;
            r_b      <= opb;
            r_sub    <= sub;
            r_carry  <= sub ? 1'b1 : cin_in;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IDXW'(i)) begin
              r_result[8*i +: 8] <= add_sum;
            end
          end
          r_carry <= add_cout;
          if (r_idx == LAST) begin
            r_idx   <= '0;
            r_cout  <= add_cout;
            r_ovf   <= w_ovf;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule
